// File: rtl/dec_stage.sv
// -----------------------------------------------------------------------------
// dec_stage -- registered RISC-V (RV32I / RV64I base) instruction decoder stage
//
// Takes one 32-bit instruction per valid/ready handshake from fetch and presents
// the decoded fields one cycle later on a valid/ready execute-side interface.
//
// Parameters
//   XLEN           datapath width, 32 or 64
//   ILLEGAL_CNT_W  width of the saturating illegal-instruction counter
//
// Ports
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready        fetch handshake; in_inst, in_pc fetch payload
//   out_valid/out_ready      execute handshake; out_pc plus decoded fields:
//     rd, rs1, rs2           register indices
//     imm                    sign-extended immediate (type dependent)
//     alu_op                 {modifier bit, funct3}
//     inst_type              instruction class code (0 = none / illegal)
//     is_mem_sign, is_word   !funct3[2], RV64 *W-form marker
//     illegal                instruction not recognised
//   flush                    drop everything in flight at the next edge
//   illegal_cnt              transfers carrying illegal=1, saturating
//
// Build option
//   DEC_STAGE_SKID_EN  when defined, adds a one-entry skid buffer so in_ready
//                      comes from a register and throughput is kept under
//                      toggling back-pressure. Undefined: a single output
//                      register with a combinational in_ready.
// -----------------------------------------------------------------------------
module dec_stage #(
    parameter int XLEN          = 32,
    parameter int ILLEGAL_CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [4:0]               rd,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [XLEN-1:0]          imm,
    output logic [3:0]               alu_op,
    output logic [4:0]               inst_type,
    output logic                     is_mem_sign,
    output logic                     is_word,
    output logic                     illegal,
    input  logic                     flush,
    output logic [ILLEGAL_CNT_W-1:0] illegal_cnt
);

    localparam bit RV64 = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic [4:0]      inst_type;
        logic            is_mem_sign;
        logic            is_word;
        logic            illegal;
    } dec_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            dec_ok;
    dec_t            dec_d;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];

    // inst[31] is the sign bit of every format; it fills the replicated top bits.
    assign imm_i = {{(XLEN-11){in_inst[31]}}, in_inst[30:20]};
    assign imm_s = {{(XLEN-11){in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
    assign imm_b = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    always_comb begin
        dec_ok            = 1'b1;
        dec_d             = '0;
        dec_d.pc          = in_pc;
        dec_d.rd          = in_inst[11:7];
        dec_d.rs1         = in_inst[19:15];
        dec_d.rs2         = in_inst[24:20];
        dec_d.is_mem_sign = ~funct3[2];
        case (opcode)
            7'h13, 7'h1B: begin
                // RV32 has no *W forms and shift amounts stop at 31 (inst[25]=0).
                if ((opcode == 7'h1B && !RV64) ||
                    (funct3[1:0] == 2'b01 && in_inst[25] && !RV64)) begin
                    dec_ok = 1'b0;
                end
                dec_d.inst_type = 5'd1;
                dec_d.imm       = imm_i;
                dec_d.alu_op    = {in_inst[30] & (funct3 == 3'b101), funct3};
                dec_d.is_word   = opcode[3];
            end
            7'h33, 7'h3B: begin
                if (opcode == 7'h3B && !RV64) begin
                    dec_ok = 1'b0;
                end
                dec_d.inst_type = 5'd2;
                dec_d.alu_op    = {in_inst[30], funct3};
                dec_d.is_word   = opcode[3];
            end
            7'h37: begin
                dec_d.inst_type = 5'd3;
                dec_d.imm       = imm_u;
            end
            7'h17: begin
                dec_d.inst_type = 5'd4;
                dec_d.imm       = imm_u;
            end
            7'h6F: begin
                dec_d.inst_type = 5'd5;
                dec_d.imm       = imm_j;
            end
            7'h67: begin
                dec_d.inst_type = 5'd6;
                dec_d.imm       = imm_i;
            end
            7'h63: begin
                dec_d.inst_type = 5'd7;
                dec_d.imm       = imm_b;
                dec_d.alu_op    = {1'b0, funct3};
            end
            7'h73: begin
                // Only the bare ECALL/EBREAK encodings are supported.
                dec_ok          = (in_inst[31:21] == 11'd0) && (funct3 == 3'b000);
                dec_d.inst_type = in_inst[20] ? 5'd8 : 5'd9;
            end
            7'h03: begin
                // LD (011) and LWU (110) exist only in RV64; 111 is never a load.
                dec_ok          = (funct3 != 3'b111) &&
                                  (RV64 || !(funct3 == 3'b011 || funct3 == 3'b110));
                dec_d.inst_type = {3'b100, funct3[1:0]};
                dec_d.imm       = imm_i;
            end
            7'h23: begin
                dec_ok          = !funct3[2] && (RV64 || funct3 != 3'b011);
                dec_d.inst_type = {3'b101, funct3[1:0]};
                dec_d.imm       = imm_s;
            end
            default: dec_ok = 1'b0;
        endcase
        if (!dec_ok || in_inst[1:0] != 2'b11) begin
            dec_d.inst_type = 5'd0;
            dec_d.imm       = '0;
            dec_d.alu_op    = 4'd0;
            dec_d.is_word   = 1'b0;
            dec_d.illegal   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output register, optional skid entry, handshakes
    // ------------------------------------------------------------------
    dec_t out_q;
    logic out_valid_q;
    logic accept;
    logic xfer;

    assign xfer = out_valid_q & out_ready;

`ifdef DEC_STAGE_SKID_EN
    dec_t skid_q;
    logic skid_valid_q;
    logic out_free;

    // Ready is the registered "skid empty" flag; flush forces it high because
    // whatever arrives during a flush is discarded anyway.
    assign in_ready = ~skid_valid_q | flush;
    assign accept   = in_valid & in_ready & ~flush;
    assign out_free = ~out_valid_q | out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // in_ready is low while the skid is full, so no accept here.
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= accept;
                if (accept) begin
                    out_q <= dec_d;
                end
            end
        end else if (accept) begin
            skid_q       <= dec_d;
            skid_valid_q <= 1'b1;
        end
    end
`else
    // Flush empties the stage, so ready may be raised for that cycle too.
    assign in_ready = ~out_valid_q | out_ready | flush;
    assign accept   = in_valid & in_ready & ~flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (~out_valid_q | out_ready) begin
            out_valid_q <= accept;
            if (accept) begin
                out_q <= dec_d;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Illegal-instruction counter: counts completed transfers only
    // ------------------------------------------------------------------
    logic [ILLEGAL_CNT_W-1:0] illegal_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegal_cnt_q <= '0;
        end else if (xfer && out_q.illegal && illegal_cnt_q != '1) begin
            illegal_cnt_q <= illegal_cnt_q + 1'b1;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign rd          = out_q.rd;
    assign rs1         = out_q.rs1;
    assign rs2         = out_q.rs2;
    assign imm         = out_q.imm;
    assign alu_op      = out_q.alu_op;
    assign inst_type   = out_q.inst_type;
    assign is_mem_sign = out_q.is_mem_sign;
    assign is_word     = out_q.is_word;
    assign illegal     = out_q.illegal;
    assign illegal_cnt = illegal_cnt_q;

endmodule
